// File: rtl/if_stage_pkg.sv
// Constants and bundle types shared by the fetch stage and its helpers.
// Next-PC source encodings, the NOP word and the fetch exception code.
package if_stage_pkg;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        exc;
        logic [4:0]  excode;
    } if_id_t;

endpackage

// File: rtl/if_stage_npc.sv
// Next-PC selection; redirect targets come from the instruction in D
// because the branch resolves there and the delay slot is already in F.
module npc
    import if_stage_pkg::*;
(
    input  logic [31:0] pc_F,
    input  logic [31:0] pc_D,
    input  logic [25:0] idx,
    input  logic [31:0] rs_D,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc4       = pc_F + 32'd4;
    assign br_target = pc_D + 32'd4
                     + {{14{idx[15]}}, idx[15:0], 2'b00};
    assign j_target  = {pc_D[31:28], idx, 2'b00};

    always_comb begin
        next_pc = pc4;
        unique case (npc_sel)
            NPC_PC4: next_pc = pc4;
            NPC_BR:  next_pc = br_taken ? br_target : pc4;
            NPC_J:   next_pc = j_target;
            NPC_JR:  next_pc = rs_D;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, fetch-address fault check and IF/ID register.
// Redirects never flush IF/ID; stall freezes both PC and IF/ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_F,
    input  logic [31:0] instr_F,
    input  logic        stall,
    input  logic        flush_D,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] rs_D,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        exc_D,
    output logic [4:0]  excode_D
);

    // 33-bit end bound so a window touching 2^32 does not wrap
    localparam logic [32:0] PC_END =
        {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

    if_id_t      id_q;
    logic [31:0] next_pc;
    logic        fault;

    npc u_npc (
        .pc_F     (pc_F),
        .pc_D     (id_q.pc),
        .idx      (id_q.instr[25:0]),
        .rs_D     (rs_D),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .next_pc  (next_pc)
    );

    assign fault = (pc_F[1:0] != 2'b00)
                || (pc_F < PC_RESET)
                || ({1'b0, pc_F} >= PC_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_F        <= PC_RESET;
            id_q.instr  <= NOP_INSTR;
            id_q.pc     <= PC_RESET;
            id_q.pc8    <= PC_RESET + 32'd8;
            id_q.exc    <= 1'b0;
            id_q.excode <= 5'd0;
        end else if (!stall) begin
            pc_F     <= next_pc;
            id_q.pc  <= pc_F;
            id_q.pc8 <= pc_F + 32'd8;
            if (flush_D) begin
                id_q.instr  <= NOP_INSTR;
                id_q.exc    <= 1'b0;
                id_q.excode <= 5'd0;
            end else if (fault) begin
                id_q.instr  <= NOP_INSTR;
                id_q.exc    <= 1'b1;
                id_q.excode <= EXC_ADEL;
            end else begin
                id_q.instr  <= instr_F;
                id_q.exc    <= 1'b0;
                id_q.excode <= 5'd0;
            end
        end
    end

    assign instr_D  = id_q.instr;
    assign pc_D     = id_q.pc;
    assign pc8_D    = id_q.pc8;
    assign exc_D    = id_q.exc;
    assign excode_D = id_q.excode;

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage against a behavioural fetch model,
// plus directed scenarios pinned with hand-computed values.
module tb_if_stage;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          IM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic        stall;
    logic        flush_D;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] rs_D;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        exc_D;
    logic [4:0]  excode_D;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    logic [31:0] imem [IM_WORDS];

    logic [31:0] m_pc_F, m_instr_D, m_pc_D, m_pc8_D;
    logic        m_exc;
    logic [4:0]  m_excode;

    if_stage #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_F     (pc_F),
        .instr_F  (instr_F),
        .stall    (stall),
        .flush_D  (flush_D),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .rs_D     (rs_D),
        .instr_D  (instr_D),
        .pc_D     (pc_D),
        .pc8_D    (pc8_D),
        .exc_D    (exc_D),
        .excode_D (excode_D)
    );

    always #5 clk = ~clk;

    function automatic bit in_window(input logic [31:0] a);
        longint unsigned lo, hi;
        lo = longint'(PC_RESET);
        hi = lo + 4 * IM_WORDS;
        return (a[1:0] == 2'b00) && (longint'(a) >= lo)
            && (longint'(a) < hi);
    endfunction

    function automatic logic [31:0] imem_rd(input logic [31:0] a);
        if (!in_window(a)) return 32'hFFFF_FFFF;
        return imem[(a - PC_RESET) >> 2];
    endfunction

    always_comb instr_F = imem_rd(pc_F);

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_pc_F    = PC_RESET;
        m_instr_D = 32'h0;
        m_pc_D    = PC_RESET;
        m_pc8_D   = PC_RESET + 32'd8;
        m_exc     = 1'b0;
        m_excode  = 5'd0;
    endtask

    // One clock of the fetch stage, from the architectural rules.
    task automatic model_step();
        logic [31:0] nxt, br_t, off;
        if (reset) begin
            model_reset();
            return;
        end
        if (stall) return;
        off  = {{16{m_instr_D[15]}}, m_instr_D[15:0]};
        br_t = m_pc_D + 32'd4 + off * 32'd4;
        case (npc_sel)
            2'b00: nxt = m_pc_F + 32'd4;
            2'b01: nxt = br_taken ? br_t : m_pc_F + 32'd4;
            2'b10: nxt = {m_pc_D[31:28], m_instr_D[25:0], 2'b00};
            default: nxt = rs_D;
        endcase
        m_pc_D  = m_pc_F;
        m_pc8_D = m_pc_F + 32'd8;
        if (flush_D) begin
            m_instr_D = 32'h0; m_exc = 1'b0; m_excode = 5'd0;
        end else if (!in_window(m_pc_F)) begin
            m_instr_D = 32'h0; m_exc = 1'b1; m_excode = 5'd4;
        end else begin
            m_instr_D = imem_rd(m_pc_F); m_exc = 1'b0; m_excode = 5'd0;
        end
        m_pc_F = nxt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit s, input bit f,
                         input logic [1:0] sel, input bit bt,
                         input logic [31:0] rs);
        stall = s; flush_D = f; npc_sel = sel; br_taken = bt; rs_D = rs;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_F", pc_F, m_pc_F);
            check("instr_D", instr_D, m_instr_D);
            check("pc_D", pc_D, m_pc_D);
            check("pc8_D", pc8_D, m_pc8_D);
            check("exc_D", {31'b0, exc_D}, {31'b0, m_exc});
            check("excode_D", {27'b0, excode_D}, {27'b0, m_excode});
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_pc_F", pc_F, PC_RESET);
        check("async_rst_instr_D", instr_D, 32'h0);
        check("async_rst_pc8_D", pc8_D, PC_RESET + 32'd8);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int r;
        for (int i = 0; i < IM_WORDS; i++) imem[i] = $urandom;
        imem[0] = 32'h2408_0001;
        imem[4] = 32'h1000_FFFC;
        imem[8] = 32'h0800_0C10;
        drive(0, 0, 2'b00, 0, 32'h0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        check("rst_pc_F", pc_F, 32'h3000);
        check("rst_pc_D", pc_D, 32'h3000);
        check("rst_pc8_D", pc8_D, 32'h3008);
        cyc();
        check("seq_pc_F1", pc_F, 32'h3004);
        check("seq_instr_D1", instr_D, 32'h2408_0001);
        check("seq_pc_D1", pc_D, 32'h3000);
        cyc();
        check("seq_pc_F2", pc_F, 32'h3008);
        check("seq_pc8_D2", pc8_D, 32'h300C);
        repeat (3) cyc();
        check("beq_in_D", pc_D, 32'h3010);
        drive(0, 0, 2'b01, 1, 32'h0);
        cyc();
        check("beq_slot_pc_D", pc_D, 32'h3014);
        check("beq_target", pc_F, 32'h3004);
        drive(0, 0, 2'b00, 0, 32'h0);
        for (int k = 0; k < 32 && m_pc_D != 32'h3020; k++) cyc();
        check("j_in_D", pc_D, 32'h3020);
        drive(0, 0, 2'b10, 0, 32'h0);
        cyc();
        check("j_slot_pc_D", pc_D, 32'h3024);
        check("j_target", pc_F, 32'h3040);

        drive(1, 0, 2'b11, 0, 32'h3100);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_pc_F", pc_F, 32'h3040);
            check("stall_pc_D", pc_D, 32'h3024);
        end
        stall = 1'b0;
        cyc();
        check("jr_after_stall", pc_F, 32'h3100);

        drive(0, 0, 2'b11, 0, 32'h3002);
        cyc();
        drive(0, 0, 2'b00, 0, 32'h0);
        cyc();
        check("mis_exc", {31'b0, exc_D}, 32'd1);
        check("mis_code", {27'b0, excode_D}, 32'd4);
        check("mis_instr", instr_D, 32'h0);
        check("mis_pc_D", pc_D, 32'h3002);
        drive(0, 0, 2'b11, 0, 32'h7000);
        cyc();
        drive(0, 0, 2'b00, 0, 32'h0);
        cyc();
        check("oor_exc", {31'b0, exc_D}, 32'd1);
        check("oor_code", {27'b0, excode_D}, 32'd4);
        check("oor_pc_D", pc_D, 32'h7000);

        drive(0, 0, 2'b11, 0, 32'h3FFC);
        cyc();
        drive(0, 0, 2'b00, 0, 32'h0);
        cyc();
        check("top_word_ok", {31'b0, exc_D}, 32'd0);
        cyc();
        check("past_top_pc_D", pc_D, 32'h4000);
        check("past_top_exc", {31'b0, exc_D}, 32'd1);
        drive(0, 0, 2'b11, 0, 32'h2FFC);
        cyc();
        drive(0, 0, 2'b00, 0, 32'h0);
        cyc();
        check("below_exc", {31'b0, exc_D}, 32'd1);

        drive(0, 0, 2'b11, 0, 32'h3000);
        cyc();
        drive(0, 0, 2'b00, 0, 32'h0);
        cyc();
        drive(1, 1, 2'b00, 0, 32'h0);
        cyc();
        check("sf_pc_F", pc_F, 32'h3004);
        check("sf_instr_D", instr_D, 32'h2408_0001);
        drive(0, 1, 2'b00, 0, 32'h0);
        cyc();
        check("fl_instr_D", instr_D, 32'h0);
        check("fl_pc_F", pc_F, 32'h3008);
        check("fl_pc_D", pc_D, 32'h3004);

        drive(1, 0, 2'b11, 0, 32'h3200);
        cyc();
        do_reset();
        drive(0, 0, 2'b00, 0, 32'h0);
        cyc();
        check("post_rst_pc_D", pc_D, 32'h3000);
        check("post_rst_instr", instr_D, 32'h2408_0001);

        for (int n = 0; n < 3000; n++) begin
            logic [1:0]  sel;
            logic [31:0] rs;
            r = $urandom_range(0, 99);
            sel = (r < 70) ? 2'b00 : (r < 80) ? 2'b01
                : (r < 87) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 9);
            rs = (r < 7) ? PC_RESET + 4 * $urandom_range(0, IM_WORDS - 1)
               : (r < 9) ? PC_RESET + $urandom_range(0, 4 * IM_WORDS - 1)
               : $urandom;
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  sel, 1'($urandom_range(0, 1)), rs);
            cyc();
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
